// File: rtl/mips_io_pkg.sv
// Shared constants for the MIPS memory-mapped I/O port: register word addresses
// and the bit layout of the status/control register.
package mips_io_pkg;

    localparam logic [31:0] ADDR_PORT_OUT = 32'h1001_0024;
    localparam logic [31:0] ADDR_PORT_IN  = 32'h1001_0028;
    localparam logic [31:0] ADDR_STATUS   = 32'h1001_002C;

    localparam int FLAG_LSB = 0;
    localparam int EN_LSB   = 8;
    localparam int LVL_LSB  = 16;
    localparam int FIELD_W  = 8;

endpackage

// File: rtl/mips_io_port_if.sv
// Data-bus view of the I/O port as seen from the core's lw/sw path.
interface mips_io_port_if;
    import mips_io_pkg::*;

    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output Address, WriteData, MemWrite, MemRead,
        input  ReadData, Hit
    );

    modport slave (
        input  Address, WriteData, MemWrite, MemRead,
        output ReadData, Hit
    );

endinterface

// File: rtl/io_debounce_bit.sv
// One input pin: two-flop synchroniser, stability counter, accepted level and
// a single-cycle pulse that is high on the edge where the level goes 0->1.
module io_debounce_bit
    import mips_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_done;

    // The count only advances while the synced pin disagrees with the accepted level.
    assign w_done = (r_s2 != r_level) && (r_cnt == CNT_LAST);
    assign rise   = w_done && r_s2;
    assign level  = r_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= pin;
            r_s2 <= r_s1;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mips_io_port.sv
// Memory-mapped I/O peripheral: PortOut register, debounced PortIn with sticky
// rising-edge flags, per-pin interrupt enables and a registered Irq.
module mips_io_port #(
    parameter int          IN_WIDTH        = 8,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] ADDR_PORT_OUT   = mips_io_pkg::ADDR_PORT_OUT,
    parameter logic [31:0] ADDR_PORT_IN    = mips_io_pkg::ADDR_PORT_IN,
    parameter logic [31:0] ADDR_STATUS     = mips_io_pkg::ADDR_STATUS
) (
    input  logic                clk,
    input  logic                reset,
    mips_io_port_if.slave       bus,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         PortOut,
    output logic                Irq
);
    import mips_io_pkg::*;

    logic [IN_WIDTH-1:0] w_level;
    logic [IN_WIDTH-1:0] w_rise;
    logic [IN_WIDTH-1:0] w_w1c;
    logic [IN_WIDTH-1:0] r_flags;
    logic [IN_WIDTH-1:0] r_en;
    logic [31:0]         r_port_out;
    logic                r_irq;

    logic                w_sel_out;
    logic                w_sel_in;
    logic                w_sel_st;
    logic                w_hit;
    logic                w_wr_out;
    logic                w_wr_st;
    logic [FIELD_W-1:0]  w_flag_f;
    logic [FIELD_W-1:0]  w_en_f;
    logic [FIELD_W-1:0]  w_lvl_f;
    logic [31:0]         w_status;
    logic [31:0]         w_lvl_word;
    logic [31:0]         w_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < IN_WIDTH; gi++) begin : g_pin
            io_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk  (clk),
                .reset(reset),
                .pin  (PortIn[gi]),
                .level(w_level[gi]),
                .rise (w_rise[gi])
            );
        end
    endgenerate

    // Full-width compare also rejects any misaligned byte address.
    assign w_sel_out = (bus.Address == ADDR_PORT_OUT);
    assign w_sel_in  = (bus.Address == ADDR_PORT_IN);
    assign w_sel_st  = (bus.Address == ADDR_STATUS);
    assign w_hit     = reset && (bus.MemRead || bus.MemWrite) && (w_sel_out || w_sel_in || w_sel_st);
    assign w_wr_out  = bus.MemWrite && w_sel_out;
    assign w_wr_st   = bus.MemWrite && w_sel_st;
    assign w_w1c     = w_wr_st ? bus.WriteData[FLAG_LSB +: IN_WIDTH] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_port_out <= '0;
            r_flags    <= '0;
            r_en       <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_out) r_port_out <= bus.WriteData;
            if (w_wr_st)  r_en       <= bus.WriteData[EN_LSB +: IN_WIDTH];
            // A rise on the same edge as its W1C keeps the flag set.
            r_flags <= (r_flags & ~w_w1c) | w_rise;
            r_irq   <= |(r_flags & r_en);
        end
    end

    always_comb begin
        w_flag_f                  = '0;
        w_en_f                    = '0;
        w_lvl_f                   = '0;
        w_lvl_word                = '0;
        w_status                  = '0;
        w_flag_f[IN_WIDTH-1:0]    = r_flags;
        w_en_f[IN_WIDTH-1:0]      = r_en;
        w_lvl_f[IN_WIDTH-1:0]     = w_level;
        w_lvl_word[IN_WIDTH-1:0]  = w_level;
        w_status[FLAG_LSB +: FIELD_W] = w_flag_f;
        w_status[EN_LSB +: FIELD_W]   = w_en_f;
        w_status[LVL_LSB +: FIELD_W]  = w_lvl_f;
        w_rdata = '0;
        if (bus.MemRead && w_hit) begin
            if (w_sel_out)     w_rdata = r_port_out;
            else if (w_sel_in) w_rdata = w_lvl_word;
            else               w_rdata = w_status;
        end
    end

    assign bus.ReadData = w_rdata;
    assign bus.Hit      = w_hit;
    assign PortOut      = r_port_out;
    assign Irq          = r_irq;

endmodule

// File: tb/tb_mips_io_port.sv
// Directed bench for mips_io_port: stimulus pushes expectations into a queue,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_mips_io_port;

    localparam logic [31:0] A_OUT = 32'h1001_0024;
    localparam logic [31:0] A_IN  = 32'h1001_0028;
    localparam logic [31:0] A_ST  = 32'h1001_002C;

    localparam byte K_RD  = 0;
    localparam byte K_HIT = 1;
    localparam byte K_PO  = 2;
    localparam byte K_IRQ = 3;

    typedef struct {
        byte         kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        Irq;

    exp_t        q[$];
    exp_t        m_e;
    logic [31:0] m_act;
    int          checks = 0;
    int          errors = 0;

    mips_io_port_if bus ();

    mips_io_port #(
        .IN_WIDTH(8),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .PortIn (PortIn),
        .PortOut(PortOut),
        .Irq    (Irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            case (m_e.kind)
                K_RD:    m_act = bus.ReadData;
                K_HIT:   m_act = {31'b0, bus.Hit};
                K_PO:    m_act = PortOut;
                default: m_act = {31'b0, Irq};
            endcase
            checks++;
            if (m_act !== m_e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", m_e.name, m_act, m_e.exp);
            end
        end
    end

    task automatic expect_val(input byte k, input string n, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.name = n;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        bus.Address   = 32'h0;
        bus.WriteData = 32'h0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] v, input string n);
        bus.Address = a;
        bus.MemRead = 1'b1;
        expect_val(K_HIT, {n, "_hit"}, 32'd1);
        expect_val(K_RD, n, v);
        step(1);
        idle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Address   = a;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        step(1);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        reset  = 1'b0;
        PortIn = 8'h00;
        step(3);
        reset = 1'b1;
        step(2);

        // Reset mid-run with pins high and state populated
        wr(A_OUT, 32'h1234_5678);
        PortIn = 8'hFF;
        step(25);
        wr(A_ST, 32'h0000_0100);
        step(2);
        expect_val(K_IRQ, "pre_reset_irq", 32'd1);
        step(1);
        reset       = 1'b0;
        bus.Address = A_ST;
        bus.MemRead = 1'b1;
        expect_val(K_PO,  "rst_portout", 32'h0);
        expect_val(K_IRQ, "rst_irq", 32'd0);
        expect_val(K_HIT, "rst_hit", 32'd0);
        expect_val(K_RD,  "rst_rdata", 32'h0);
        step(1);
        idle();
        step(2);
        reset = 1'b1;
        rd(A_ST, 32'h0, "status_after_reset");
        step(16);
        rd(A_IN, 32'h0000_0000, "level_edge17");
        rd(A_IN, 32'h0000_00FF, "level_edge18");
        rd(A_ST, 32'h00FF_00FF, "status_all_rise");
        PortIn = 8'h00;
        step(20);
        wr(A_ST, 32'h0000_00FF);
        rd(A_ST, 32'h0, "status_cleared");

        // PortOut write/read and misaligned write
        bus.Address   = A_OUT;
        bus.WriteData = 32'hDEAD_BEEF;
        bus.MemWrite  = 1'b1;
        expect_val(K_HIT, "sw_out_hit", 32'd1);
        expect_val(K_PO, "portout_before_edge", 32'h0);
        step(1);
        idle();
        expect_val(K_PO, "portout_after_sw", 32'hDEAD_BEEF);
        rd(A_OUT, 32'hDEAD_BEEF, "lw_portout");
        bus.Address   = 32'h1001_0025;
        bus.WriteData = 32'h1111_1111;
        bus.MemWrite  = 1'b1;
        expect_val(K_HIT, "misaligned_sw_hit", 32'd0);
        step(1);
        idle();
        expect_val(K_PO, "portout_unchanged", 32'hDEAD_BEEF);
        bus.Address   = A_IN;
        bus.WriteData = 32'hFFFF_FFFF;
        bus.MemWrite  = 1'b1;
        expect_val(K_HIT, "sw_portin_hit", 32'd1);
        step(1);
        idle();
        rd(A_IN, 32'h0, "portin_ignores_sw");

        // Glitch rejection, then a clean pulse
        PortIn = 8'h01;
        step(10);
        PortIn = 8'h00;
        step(25);
        rd(A_IN, 32'h0, "glitch_level");
        rd(A_ST, 32'h0, "glitch_flag");
        PortIn = 8'h01;
        step(17);
        rd(A_IN, 32'h0, "pin0_edge17");
        rd(A_IN, 32'h1, "pin0_edge18");
        rd(A_ST, 32'h0001_0001, "pin0_flag");
        step(1);
        PortIn = 8'h00;
        step(20);
        wr(A_ST, 32'h0000_0001);
        rd(A_ST, 32'h0, "pin0_flag_w1c");

        // Interrupt enable and clear
        wr(A_ST, 32'h0000_0100);
        PortIn = 8'h01;
        step(17);
        expect_val(K_IRQ, "irq_idle", 32'd0);
        rd(A_ST, 32'h0000_0100, "irq_pre_flag");
        expect_val(K_IRQ, "irq_same_cycle_as_flag", 32'd0);
        rd(A_ST, 32'h0001_0101, "irq_flag_set");
        expect_val(K_IRQ, "irq_asserted", 32'd1);
        wr(A_ST, 32'h0000_0101);
        expect_val(K_IRQ, "irq_lag_after_w1c", 32'd1);
        rd(A_ST, 32'h0001_0100, "irq_flag_cleared");
        expect_val(K_IRQ, "irq_deasserted", 32'd0);
        step(1);

        // W1C on the same edge as a rise
        PortIn = 8'h09;
        step(17);
        wr(A_ST, 32'h0000_0008);
        rd(A_ST, 32'h0009_0008, "collision_set_wins");

        // Unmapped / misaligned reads, settled status
        bus.Address = 32'h1001_0030;
        bus.MemRead = 1'b1;
        expect_val(K_HIT, "unmapped_hit", 32'd0);
        expect_val(K_RD,  "unmapped_rdata", 32'h0);
        step(1);
        bus.Address = 32'h1001_0026;
        expect_val(K_HIT, "misaligned_lw_hit", 32'd0);
        expect_val(K_RD,  "misaligned_lw_rdata", 32'h0);
        step(1);
        idle();
        PortIn = 8'h05;
        step(20);
        rd(A_ST, 32'h0005_000C, "status_settled_05");

        step(2);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
